// File: rtl/issue_scoreboard_pkg.sv
// Shared types and widths for the issue scoreboard: register-address width,
// the default sequence-number width and the decode allocation request payload.
package issue_scoreboard_pkg;

  localparam int unsigned SEQ_NUM_BITS_DEF = 5;
  localparam int unsigned REG_ADDR_BITS    = 5;
  localparam int unsigned NUM_REGS         = 1 << REG_ADDR_BITS;

  typedef logic [REG_ADDR_BITS-1:0] t_reg_addr;

  typedef struct packed {
    t_reg_addr rs1;
    t_reg_addr rs2;
    logic      rs1_en;
    logic      rs2_en;
    t_reg_addr waddr;
    logic      wen;
  } t_sb_alloc;

  // A register operand only matters when enabled and not x0.
  function automatic logic reg_used(input t_reg_addr addr, input logic en);
    return en && (addr != '0);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback-facing bundle of the issue scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS_DEF
) ();

  logic                      alloc_val;
  logic                      alloc_rdy;
  t_reg_addr                 alloc_rs1;
  t_reg_addr                 alloc_rs2;
  logic                      alloc_rs1_en;
  logic                      alloc_rs2_en;
  t_reg_addr                 alloc_waddr;
  logic                      alloc_wen;
  logic [p_seq_num_bits-1:0] alloc_seq_num;
  logic                      complete_val;
  logic [p_seq_num_bits-1:0] complete_seq_num;
  t_reg_addr                 complete_waddr;
  logic                      complete_wen;
  logic                      empty;

  modport master (
    output alloc_val, alloc_rs1, alloc_rs2, alloc_rs1_en, alloc_rs2_en,
           alloc_waddr, alloc_wen,
           complete_val, complete_seq_num, complete_waddr, complete_wen,
    input  alloc_rdy, alloc_seq_num, empty
  );

  modport slave (
    input  alloc_val, alloc_rs1, alloc_rs2, alloc_rs1_en, alloc_rs2_en,
           alloc_waddr, alloc_wen,
           complete_val, complete_seq_num, complete_waddr, complete_wen,
    output alloc_rdy, alloc_seq_num, empty
  );

endinterface

// File: rtl/issue_scoreboard_seq_num_ring.sv
// In-order sequence-number ring: allocates at tail, marks completions done,
// and retires at most one done head entry per cycle.
module seq_num_ring #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  output logic                      complete_ok,
  output logic                      full,
  output logic                      empty,
  output logic [p_seq_num_bits-1:0] tail
);

  localparam int unsigned DEPTH    = 1 << p_seq_num_bits;
  localparam int unsigned CNT_BITS = p_seq_num_bits + 1;

  logic [DEPTH-1:0]          in_flight;
  logic [DEPTH-1:0]          done;
  logic [p_seq_num_bits-1:0] head;
  logic [p_seq_num_bits-1:0] tail_q;
  logic [CNT_BITS-1:0]       count;
  logic                      retire;

  assign complete_ok = complete_val && in_flight[complete_seq_num];
  assign retire      = in_flight[head] && done[head];
  assign full        = (count == CNT_BITS'(DEPTH));
  assign empty       = (count == '0);
  assign tail        = tail_q;

  // Retire is applied last so it wins over a duplicate completion of the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
      done      <= '0;
      head      <= '0;
      tail_q    <= '0;
      count     <= '0;
    end else begin
      if (alloc) begin
        in_flight[tail_q] <= 1'b1;
        done[tail_q]      <= 1'b0;
        tail_q            <= tail_q + p_seq_num_bits'(1);
      end
      if (complete_ok) begin
        done[complete_seq_num] <= 1'b1;
      end
      if (retire) begin
        in_flight[head] <= 1'b0;
        done[head]      <= 1'b0;
        head            <= head + p_seq_num_bits'(1);
      end
      case ({alloc, retire})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && complete_val) begin
      assert (in_flight[complete_seq_num])
        else $error("seq_num_ring: completion of seq %0d which is not in flight", complete_seq_num);
    end
  end
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: program-order seq allocation, per-register pending writer
// table and RAW/full issue gating. Optional ISSUE_SCOREBOARD_BYPASS_EN lets a
// same-cycle completion unblock its dependent instruction.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS_DEF
) (
  input logic               clk,
  input logic               rst,
  issue_scoreboard_if.slave sb
);

  t_sb_alloc                 req;
  logic [NUM_REGS-1:0]       pend;
  logic [p_seq_num_bits-1:0] writer [NUM_REGS];
  logic                      complete_ok;
  logic                      full;
  logic                      ring_empty;
  logic [p_seq_num_bits-1:0] tail;
  logic                      clr;
  logic                      set;
  logic                      fire;
  logic                      rs1_busy;
  logic                      rs2_busy;
  logic                      hazard;

  assign req = '{rs1:    sb.alloc_rs1,
                 rs2:    sb.alloc_rs2,
                 rs1_en: sb.alloc_rs1_en,
                 rs2_en: sb.alloc_rs2_en,
                 waddr:  sb.alloc_waddr,
                 wen:    sb.alloc_wen};

  seq_num_ring #(.p_seq_num_bits(p_seq_num_bits)) u_ring (
    .clk              (clk),
    .rst              (rst),
    .alloc            (fire),
    .complete_val     (sb.complete_val),
    .complete_seq_num (sb.complete_seq_num),
    .complete_ok      (complete_ok),
    .full             (full),
    .empty            (ring_empty),
    .tail             (tail)
  );

  // Only the newest writer of a register may clear its pending bit.
  assign clr = complete_ok && sb.complete_wen && pend[sb.complete_waddr]
               && (writer[sb.complete_waddr] == sb.complete_seq_num);

  always_comb begin
    rs1_busy = reg_used(req.rs1, req.rs1_en) && pend[req.rs1];
    rs2_busy = reg_used(req.rs2, req.rs2_en) && pend[req.rs2];
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    if (clr && (sb.complete_waddr == req.rs1)) rs1_busy = 1'b0;
    if (clr && (sb.complete_waddr == req.rs2)) rs2_busy = 1'b0;
`endif
    hazard = rs1_busy || rs2_busy;
  end

  assign sb.alloc_rdy     = !full && !hazard;
  assign sb.alloc_seq_num = tail;
  assign sb.empty         = ring_empty;

  assign fire = sb.alloc_val && sb.alloc_rdy;
  assign set  = fire && reg_used(req.waddr, req.wen);

  // Allocation is applied after the clear so a new writer wins a same-register race.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        writer[i] <= '0;
      end
    end else begin
      if (clr) begin
        pend[sb.complete_waddr] <= 1'b0;
      end
      if (set) begin
        pend[req.waddr]   <= 1'b1;
        writer[req.waddr] <= tail;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a vector table on a 5-bit-seq instance,
// plus hand sequences for mid-operation reset and ring-full wrap on a 2-bit one.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.p_seq_num_bits(5)) sb5 ();
  issue_scoreboard_if #(.p_seq_num_bits(2)) sb2 ();

  issue_scoreboard #(.p_seq_num_bits(5)) dut5 (.clk(clk), .rst(rst), .sb(sb5.slave));
  issue_scoreboard #(.p_seq_num_bits(2)) dut2 (.clk(clk), .rst(rst), .sb(sb2.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       av;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] wa;
    logic       we;
    logic       cv;
    logic [4:0] cs;
    logic [4:0] cwa;
    logic       cwe;
    logic       rdy;
    logic       rdy_b;
    logic [4:0] seq;
    logic       emp;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t v(input logic av, input int rs1, input logic e1,
                             input int rs2, input logic e2, input int wa, input logic we,
                             input logic cv, input int cs, input int cwa, input logic cwe,
                             input logic rdy, input logic rdy_b, input int seq, input logic emp);
    vec_t r;
    r.av = av; r.rs1 = 5'(rs1); r.e1 = e1; r.rs2 = 5'(rs2); r.e2 = e2;
    r.wa = 5'(wa); r.we = we; r.cv = cv; r.cs = 5'(cs); r.cwa = 5'(cwa); r.cwe = cwe;
    r.rdy = rdy; r.rdy_b = rdy_b; r.seq = 5'(seq); r.emp = emp;
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drive5(input vec_t x);
    sb5.alloc_val        = x.av;
    sb5.alloc_rs1        = x.rs1;
    sb5.alloc_rs1_en     = x.e1;
    sb5.alloc_rs2        = x.rs2;
    sb5.alloc_rs2_en     = x.e2;
    sb5.alloc_waddr      = x.wa;
    sb5.alloc_wen        = x.we;
    sb5.complete_val     = x.cv;
    sb5.complete_seq_num = x.cs;
    sb5.complete_waddr   = x.cwa;
    sb5.complete_wen     = x.cwe;
  endtask

  task automatic drive2(input logic av, input logic cv, input int cs);
    sb2.alloc_val        = av;
    sb2.alloc_rs1        = '0;
    sb2.alloc_rs1_en     = 1'b0;
    sb2.alloc_rs2        = '0;
    sb2.alloc_rs2_en     = 1'b0;
    sb2.alloc_waddr      = '0;
    sb2.alloc_wen        = 1'b0;
    sb2.complete_val     = cv;
    sb2.complete_seq_num = 2'(cs);
    sb2.complete_waddr   = '0;
    sb2.complete_wen     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //      av rs1 e1 rs2 e2 wa we  cv cs cwa cwe  rdy rdy_b seq emp
    vecs[0]  = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 1);
    vecs[1]  = v(1, 2, 1, 3, 1, 1, 1,  0, 0, 0, 0,  1, 1, 0, 1);
    vecs[2]  = v(1, 1, 1, 0, 0, 4, 1,  0, 0, 0, 0,  0, 0, 1, 0);
    vecs[3]  = v(0, 1, 1, 0, 0, 4, 1,  1, 0, 1, 1,  0, 1, 1, 0);
    vecs[4]  = v(1, 1, 1, 0, 0, 4, 1,  0, 0, 0, 0,  1, 1, 1, 0);
    vecs[5]  = v(1, 0, 1, 4, 1, 5, 1,  0, 0, 0, 0,  0, 0, 2, 0);
    vecs[6]  = v(1, 0, 1, 0, 1, 0, 1,  0, 0, 0, 0,  1, 1, 2, 0);
    vecs[7]  = v(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 3, 0);
    vecs[8]  = v(1, 0, 0, 0, 0, 5, 1,  0, 0, 0, 0,  1, 1, 3, 0);
    vecs[9]  = v(1, 0, 0, 0, 0, 5, 1,  0, 0, 0, 0,  1, 1, 4, 0);
    vecs[10] = v(0, 5, 1, 0, 0, 0, 0,  1, 3, 5, 1,  0, 0, 5, 0);
    vecs[11] = v(0, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 5, 0);
    vecs[12] = v(0, 5, 1, 0, 0, 0, 0,  1, 4, 5, 1,  0, 1, 5, 0);
    vecs[13] = v(0, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 5, 0);
    vecs[14] = v(0, 0, 0, 4, 1, 0, 0,  1, 1, 4, 1,  0, 1, 5, 0);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0,  1, 1, 5, 0);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 5, 0);
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 5, 0);
    vecs[18] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 5, 0);
    vecs[19] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 5, 1);
    vecs[20] = v(1, 0, 0, 0, 0, 6, 1,  0, 0, 0, 0,  1, 1, 5, 1);
    vecs[21] = v(1, 0, 0, 0, 0, 6, 1,  1, 5, 6, 1,  1, 1, 6, 0);
    vecs[22] = v(0, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 7, 0);
    vecs[23] = v(0, 6, 1, 0, 0, 0, 0,  1, 6, 6, 1,  0, 1, 7, 0);
    vecs[24] = v(0, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 7, 0);
    vecs[25] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 7, 1);

    rst = 1'b1;
    drive5(vecs[0]);
    drive2(1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive5(vecs[i]);
      #1;
      chk($sformatf("vec%0d rdy", i), int'(sb5.alloc_rdy), int'(BYP ? vecs[i].rdy_b : vecs[i].rdy));
      chk($sformatf("vec%0d seq", i), int'(sb5.alloc_seq_num), int'(vecs[i].seq));
      chk($sformatf("vec%0d empty", i), int'(sb5.empty), int'(vecs[i].emp));
      tick();
    end

    // Mid-operation reset: three writers in flight, completion in the reset cycle dropped.
    for (int r = 1; r <= 3; r++) begin
      drive5(v(1, 0, 0, 0, 0, r, 1,  0, 0, 0, 0,  0, 0, 0, 0));
      #1;
      chk($sformatf("rstseq alloc%0d rdy", r), int'(sb5.alloc_rdy), 1);
      tick();
    end
    drive5(v(0, 1, 1, 2, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    #1;
    chk("rstseq pre rdy", int'(sb5.alloc_rdy), 0);
    chk("rstseq pre seq", int'(sb5.alloc_seq_num), 10);
    chk("rstseq pre empty", int'(sb5.empty), 0);
    rst = 1'b1;
    drive5(v(0, 1, 1, 2, 1, 0, 0,  1, 7, 1, 1,  0, 0, 0, 0));
    tick();
    rst = 1'b0;
    drive5(v(0, 1, 1, 2, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    #1;
    chk("rstseq post empty", int'(sb5.empty), 1);
    chk("rstseq post seq", int'(sb5.alloc_seq_num), 0);
    chk("rstseq post rdy x1x2", int'(sb5.alloc_rdy), 1);
    drive5(v(0, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    #1;
    chk("rstseq post rdy x3", int'(sb5.alloc_rdy), 1);
    drive5(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));

    // Ring full and wrap on the 2-bit instance.
    tick();
    for (int k = 0; k < 4; k++) begin
      drive2(1'b1, 1'b0, 0);
      #1;
      chk($sformatf("full alloc%0d rdy", k), int'(sb2.alloc_rdy), 1);
      chk($sformatf("full alloc%0d seq", k), int'(sb2.alloc_seq_num), k);
      tick();
    end
    drive2(1'b1, 1'b0, 0);
    #1;
    chk("full rdy", int'(sb2.alloc_rdy), 0);
    chk("full seq wrap", int'(sb2.alloc_seq_num), 0);
    chk("full empty", int'(sb2.empty), 0);
    tick();
    drive2(1'b1, 1'b1, 2);
    #1;
    chk("full cmp2 rdy", int'(sb2.alloc_rdy), 0);
    tick();
    drive2(1'b1, 1'b0, 0);
    #1;
    chk("full after cmp2 rdy", int'(sb2.alloc_rdy), 0);
    tick();
    drive2(1'b0, 1'b1, 0);
    #1;
    chk("full cmp0 rdy", int'(sb2.alloc_rdy), 0);
    tick();
    drive2(1'b0, 1'b0, 0);
    tick();
    drive2(1'b1, 1'b0, 0);
    #1;
    chk("wrap rdy", int'(sb2.alloc_rdy), 1);
    chk("wrap seq", int'(sb2.alloc_seq_num), 0);
    tick();
    drive2(1'b1, 1'b0, 0);
    #1;
    chk("refull rdy", int'(sb2.alloc_rdy), 0);
    chk("refull seq", int'(sb2.alloc_seq_num), 1);
    drive2(1'b0, 1'b0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
